self_destruct_sequencer: RTL and testbench

Arming/countdown controller for the robot status board. It consumes the debounced switch levels (in-combat, danger, damaged, immobilized) and the divider strobes. It runs a 2-of-3 fault vote, a filtered arm decision and an N-second countdown with pause/abort. It drives the 8 board LEDs directly as a blinking thermometer bar, plus a sticky detonate flag.

---
 rtl/self_destruct_sequencer_if.sv | 26 ++
 rtl/self_destruct_sequencer.sv | 153 +++++++++++++++
 tb/tb_self_destruct_sequencer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/self_destruct_sequencer_if.sv
// Status-board bundle for the self-destruct sequencer:
// debounced levels and strobes in, LED bar and flags out.
interface self_destruct_sequencer_if;
  logic       tick_1s;
  logic       tick_blink;
  logic       in_combat;
  logic       danger;
  logic       damaged;
  logic       immobilized;
  logic [7:0] leds;
  logic       armed;
  logic       detonate;
  logic [3:0] remaining;

  modport master (
    output tick_1s, tick_blink, in_combat,
    output danger, damaged, immobilized,
    input  leds, armed, detonate, remaining
  );

  modport slave (
    input  tick_1s, tick_blink, in_combat,
    input  danger, damaged, immobilized,
    output leds, armed, detonate, remaining
  );
endinterface

// File: rtl/self_destruct_sequencer.sv
// Arming/countdown controller: 2-of-3 fault vote, filtered
// arm, N-second countdown with pause/abort, blinking LED bar.
module self_destruct_sequencer #(
  parameter int unsigned COUNT_MAX   = 8,
  parameter int unsigned VOTE_FILTER = 4
) (
  input logic clk,
  input logic reset,
  self_destruct_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE, COUNT, HOLD, BOOM
  } state_t;

  localparam logic [3:0] CMAX = 4'(COUNT_MAX);
  localparam logic [3:0] VFLT = 4'(VOTE_FILTER);

  state_t     r_state;
  state_t     w_nstate;
  logic [3:0] r_cnt;
  logic [3:0] w_ncnt;
  logic       r_phase;
  logic       w_nphase;
  logic [3:0] r_filt;
  logic [7:0] r_leds;
  logic [7:0] w_leds;
  logic       r_armed;
  logic       r_det;
  logic [3:0] r_rem;
  logic [3:0] w_rem;
  logic       w_vote;
  logic       w_arm;
  logic       w_to_idle;

  function automatic logic [7:0] f_therm(input logic [3:0] c);
    logic [8:0] t;
    t = (9'd1 << c) - 9'd1;
    return t[7:0];
  endfunction

  assign w_vote = (bus.danger & bus.damaged)
                | (bus.danger & bus.immobilized)
                | (bus.damaged & bus.immobilized);
  assign w_arm  = bus.in_combat & w_vote;

  // Filter: saturating run-length of arm_cond, cleared on IDLE entry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_filt <= 4'd0;
    end else if (!w_arm || w_to_idle) begin
      r_filt <= 4'd0;
    end else if (r_filt != VFLT) begin
      r_filt <= r_filt + 4'd1;
    end
  end

  // State, count and blink phase registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_phase <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
      r_phase <= w_nphase;
    end
  end

  // Next state: abort beats tick_1s beats vote loss
  always_comb begin
    w_nstate  = r_state;
    w_ncnt    = r_cnt;
    w_nphase  = r_phase;
    w_to_idle = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_ncnt   = 4'd0;
        w_nphase = 1'b0;
        if (r_filt == VFLT) w_nstate = COUNT;
      end
      COUNT: begin
        if (!bus.in_combat) begin
          w_nstate  = IDLE;
          w_ncnt    = 4'd0;
          w_nphase  = 1'b0;
          w_to_idle = 1'b1;
        end else begin
          if (bus.tick_blink) w_nphase = ~r_phase;
          if (bus.tick_1s && (r_cnt + 4'd1 == CMAX)) begin
            w_nstate = BOOM;
            w_ncnt   = CMAX;
            w_nphase = 1'b1;
          end else begin
            if (bus.tick_1s) w_ncnt = r_cnt + 4'd1;
            if (!w_vote) w_nstate = HOLD;
          end
        end
      end
      HOLD: begin
        if (!bus.in_combat) begin
          w_nstate  = IDLE;
          w_ncnt    = 4'd0;
          w_nphase  = 1'b0;
          w_to_idle = 1'b1;
        end else if (w_vote) begin
          w_nstate = COUNT;
        end
      end
      BOOM: begin
        if (bus.tick_blink) w_nphase = ~r_phase;
      end
    endcase
  end

  // Output decode from next-state values, so registered outputs track state
  always_comb begin
    w_leds = 8'h00;
    w_rem  = CMAX - w_ncnt;
    unique case (w_nstate)
      IDLE:  w_leds = 8'h00;
      COUNT: w_leds = f_therm(w_ncnt)
                    | ({7'd0, w_nphase} << w_ncnt[2:0]);
      HOLD:  w_leds = f_therm(w_ncnt);
      BOOM: begin
        w_leds = w_nphase ? 8'hFF : 8'h00;
        w_rem  = 4'd0;
      end
    endcase
  end

  // Registered board outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_leds  <= 8'h00;
      r_armed <= 1'b0;
      r_det   <= 1'b0;
      r_rem   <= CMAX;
    end else begin
      r_leds  <= w_leds;
      r_armed <= (w_nstate == COUNT) || (w_nstate == HOLD);
      r_det   <= (w_nstate == BOOM);
      r_rem   <= w_rem;
    end
  end

  assign bus.leds      = r_leds;
  assign bus.armed     = r_armed;
  assign bus.detonate  = r_det;
  assign bus.remaining = r_rem;

endmodule

// File: tb/tb_self_destruct_sequencer.sv
// Bench for self_destruct_sequencer: per-cycle model compare
// plus directed scenarios with literal expectations.
module tb_self_destruct_sequencer;

  localparam int CM = 8;
  localparam int VF = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_err = 0;
  int   n_chk = 0;

  self_destruct_sequencer_if bus();

  self_destruct_sequencer #(
    .COUNT_MAX(CM),
    .VOTE_FILTER(VF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Model: mode 0 idle, 1 counting, 2 paused, 3 exploded;
  // el = seconds elapsed, ph = blink phase, run = arm run length
  int m_mode = 0;
  int m_el = 0;
  int m_ph = 0;
  int m_run = 0;

  function automatic int exp_leds();
    case (m_mode)
      1: return (2 ** m_el - 1) + m_ph * (2 ** m_el);
      2: return 2 ** m_el - 1;
      3: return m_ph ? 255 : 0;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk) begin
    int votes;
    int run0;
    bit v;
    bit a;
    if (!reset) begin
      m_mode = 0; m_el = 0; m_ph = 0; m_run = 0;
    end else begin
      votes = int'(bus.danger) + int'(bus.damaged)
            + int'(bus.immobilized);
      v = (votes >= 2);
      a = bus.in_combat && v;
      run0 = m_run;
      m_run = a ? ((m_run < VF) ? m_run + 1 : VF) : 0;
      if (m_mode == 0) begin
        if (run0 == VF) m_mode = 1;
      end else if (m_mode == 3) begin
        if (bus.tick_blink) m_ph = 1 - m_ph;
      end else if (!bus.in_combat) begin
        m_mode = 0; m_el = 0; m_ph = 0; m_run = 0;
      end else if (m_mode == 2) begin
        if (v) m_mode = 1;
      end else begin
        if (bus.tick_blink) m_ph = 1 - m_ph;
        if (bus.tick_1s) m_el++;
        if (m_el == CM) begin
          m_mode = 3; m_ph = 1;
        end else if (!v) begin
          m_mode = 2;
        end
      end
    end
    #1;
    chk("model_leds", int'(bus.leds), exp_leds());
    chk("model_armed", int'(bus.armed),
        (m_mode == 1 || m_mode == 2) ? 1 : 0);
    chk("model_det", int'(bus.detonate), (m_mode == 3) ? 1 : 0);
    chk("model_rem", int'(bus.remaining),
        (m_mode == 3) ? 0 : CM - m_el);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick();
    bus.tick_1s = 1'b1;
    cyc(1);
    bus.tick_1s = 1'b0;
    cyc(1);
  endtask

  task automatic blink();
    bus.tick_blink = 1'b1;
    cyc(1);
    bus.tick_blink = 1'b0;
    cyc(1);
  endtask

  initial begin
    bus.tick_1s = 0; bus.tick_blink = 0; bus.in_combat = 0;
    bus.danger = 0; bus.damaged = 0; bus.immobilized = 0;
    cyc(2);
    chk("rst_leds", int'(bus.leds), 8'h00);
    chk("rst_armed", int'(bus.armed), 0);
    chk("rst_det", int'(bus.detonate), 0);
    chk("rst_rem", int'(bus.remaining), 8);
    reset = 1'b1;
    cyc(1);

    // Arm and count
    bus.in_combat = 1; bus.danger = 1; bus.damaged = 1;
    cyc(4);
    chk("arm_4clk", int'(bus.armed), 0);
    cyc(1);
    chk("arm_5clk", int'(bus.armed), 1);
    chk("arm_rem", int'(bus.remaining), 8);
    repeat (3) tick();
    chk("cnt3_rem", int'(bus.remaining), 5);
    chk("cnt3_leds", int'(bus.leds), 8'h07);
    blink();
    chk("cnt3_blink", int'(bus.leds), 8'h0F);

    // Plain abort, then re-arm
    bus.in_combat = 0;
    cyc(1);
    chk("abort_armed", int'(bus.armed), 0);
    chk("abort_leds", int'(bus.leds), 8'h00);
    bus.in_combat = 1;
    cyc(5);
    chk("rearm", int'(bus.armed), 1);

    // Pause at cnt=2
    repeat (2) tick();
    bus.damaged = 0;
    cyc(1);
    chk("hold_armed", int'(bus.armed), 1);
    chk("hold_leds", int'(bus.leds), 8'h03);
    bus.tick_1s = 1; bus.tick_blink = 1;
    cyc(1);
    bus.tick_1s = 0; bus.tick_blink = 0;
    cyc(1);
    chk("hold_frz_leds", int'(bus.leds), 8'h03);
    chk("hold_frz_rem", int'(bus.remaining), 6);
    bus.damaged = 1;
    cyc(1);
    chk("resume_rem", int'(bus.remaining), 6);
    blink();
    chk("resume_blink", int'(bus.leds), 8'h07);
    repeat (5) tick();
    chk("cnt7_rem", int'(bus.remaining), 1);

    // Abort beats tick_1s at cnt=7
    bus.tick_1s = 1; bus.in_combat = 0;
    cyc(1);
    bus.tick_1s = 0;
    chk("prio_armed", int'(bus.armed), 0);
    chk("prio_leds", int'(bus.leds), 8'h00);
    chk("prio_rem", int'(bus.remaining), 8);
    chk("prio_det", int'(bus.detonate), 0);

    // Filter reject: 3 on, 1 off, 3 on
    bus.in_combat = 1;
    for (int i = 0; i < 7; i++) begin
      bus.damaged = (i == 3) ? 1'b0 : 1'b1;
      cyc(1);
      chk("filt_armed", int'(bus.armed), 0);
    end
    bus.damaged = 0;
    cyc(2);
    chk("filt_idle", int'(bus.armed), 0);

    // Detonation, armed via danger & immobilized
    bus.immobilized = 1;
    cyc(5);
    chk("boom_armed", int'(bus.armed), 1);
    repeat (7) tick();
    chk("boom_pre_det", int'(bus.detonate), 0);
    bus.tick_1s = 1;
    cyc(1);
    bus.tick_1s = 0;
    chk("boom_det", int'(bus.detonate), 1);
    chk("boom_leds", int'(bus.leds), 8'hFF);
    chk("boom_rem", int'(bus.remaining), 0);
    blink();
    chk("boom_blink0", int'(bus.leds), 8'h00);
    blink();
    chk("boom_blink1", int'(bus.leds), 8'hFF);
    bus.in_combat = 0; bus.danger = 0;
    cyc(3);
    chk("boom_sticky", int'(bus.detonate), 1);
    chk("boom_stk_leds", int'(bus.leds), 8'hFF);

    // Async reset between edges
    #2;
    reset = 1'b0;
    #1;
    chk("areset_det", int'(bus.detonate), 0);
    chk("areset_leds", int'(bus.leds), 8'h00);
    chk("areset_rem", int'(bus.remaining), 8);
    chk("areset_armed", int'(bus.armed), 0);
    cyc(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
